// File: rtl/reqack_initiator.sv
// reqack_initiator: requester end of the req/ack/done/intrpt handshake.
// Issues a single-cycle req, waits up to MAX cycles for ack, demands done
// exactly one cycle after ack, then closes every transaction with a single
// intrpt pulse (success or error). All outputs are registered.
// Optional feature: define REQACK_INIT_RETRY_EN to re-issue req on timeout
// up to RETRY_MAX times before declaring the timeout final.
module reqack_initiator #(
  parameter int MAX       = 5,
  parameter int INTR_DLY  = 1,
  parameter int CNT_W     = 8,
  parameter int RETRY_MAX = 2
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic             ack_i,
  input  logic             done_i,
  output logic             req_o,
  output logic             intrpt_o,
  output logic             busy_o,
  output logic             timeout_err_o,
  output logic             proto_err_o,
  output logic [CNT_W-1:0] txn_count_o
);

  localparam int WCNT_W = (MAX < 1) ? 1 : $clog2(MAX + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_REQ       = 3'd1;
  localparam logic [2:0] S_WAIT_ACK  = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_INTR_WAIT = 3'd4;

  // Reject parameter values the handshake timing cannot honour.
  if (MAX < 1 || INTR_DLY < 0 || INTR_DLY > 2 || CNT_W < 1 || RETRY_MAX < 0) begin : g_bad_param
    $error("reqack_initiator: illegal parameter value");
  end

  logic [2:0]        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [1:0]        dcnt_q, dcnt_d;
  logic              req_q, intrpt_q, busy_q, terr_q, perr_q;
  logic              intrpt_d, terr_d, perr_d;
  logic [CNT_W-1:0]  txn_q, txn_d;
  logic              stray_s;

`ifdef REQACK_INIT_RETRY_EN
  localparam int RCNT_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
`endif

  assign stray_s = ack_i | done_i;

  // Next-state and next-output decision for the handshake FSM.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    dcnt_d   = dcnt_q;
    txn_d    = txn_q;
    intrpt_d = 1'b0;
    terr_d   = 1'b0;
    perr_d   = 1'b0;
`ifdef REQACK_INIT_RETRY_EN
    rcnt_d   = rcnt_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef REQACK_INIT_RETRY_EN
        rcnt_d = '0;
`endif
        perr_d = stray_s;
        if (start_i) begin
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        perr_d  = stray_s;
        wcnt_d  = WCNT_W'(1);
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (done_i) begin
          // done before or together with ack is an early completion
          perr_d  = 1'b1;
          dcnt_d  = 2'd0;
          state_d = S_INTR_WAIT;
        end else if (ack_i) begin
          state_d = S_WAIT_DONE;
        end else if (wcnt_q == WCNT_W'(MAX)) begin
`ifdef REQACK_INIT_RETRY_EN
          if (rcnt_q < RCNT_W'(RETRY_MAX)) begin
            rcnt_d  = rcnt_q + RCNT_W'(1);
            state_d = S_REQ;
          end else begin
            terr_d  = 1'b1;
            dcnt_d  = 2'd0;
            state_d = S_INTR_WAIT;
          end
`else
          terr_d  = 1'b1;
          dcnt_d  = 2'd0;
          state_d = S_INTR_WAIT;
`endif
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (done_i && !ack_i) begin
          txn_d = txn_q + CNT_W'(1);
          if (INTR_DLY == 0) begin
            intrpt_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            dcnt_d  = 2'd1;
            state_d = S_INTR_WAIT;
          end
        end else begin
          // error ends spend one extra cycle so the error pulse precedes intrpt
          perr_d  = 1'b1;
          dcnt_d  = 2'd0;
          state_d = S_INTR_WAIT;
        end
      end
      S_INTR_WAIT: begin
        if (dcnt_q == 2'(INTR_DLY)) begin
          // a stray seen while launching intrpt is dropped so pulses never overlap
          intrpt_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          perr_d = stray_s;
          dcnt_d = dcnt_q + 2'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; reset aborts any transaction.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= S_IDLE;
      wcnt_q   <= '0;
      dcnt_q   <= 2'd0;
      txn_q    <= '0;
      req_q    <= 1'b0;
      intrpt_q <= 1'b0;
      busy_q   <= 1'b0;
      terr_q   <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      dcnt_q   <= dcnt_d;
      txn_q    <= txn_d;
      req_q    <= (state_d == S_REQ);
      intrpt_q <= intrpt_d;
      busy_q   <= (state_d != S_IDLE);
      terr_q   <= terr_d;
      perr_q   <= perr_d;
    end
  end

`ifdef REQACK_INIT_RETRY_EN
  // Retry counter: number of req re-issues in the current transaction.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rcnt_q <= '0;
    end else begin
      rcnt_q <= rcnt_d;
    end
  end
`endif

  assign req_o         = req_q;
  assign intrpt_o      = intrpt_q;
  assign busy_o        = busy_q;
  assign timeout_err_o = terr_q;
  assign proto_err_o   = perr_q;
  assign txn_count_o   = txn_q;

endmodule

// File: tb/tb_reqack_initiator.sv
// Directed bench for reqack_initiator. A transaction-level model turns each
// scripted transaction (start cycle, ack offset, done behaviour) into
// per-cycle input vectors and expected output waveforms; one loop drives the
// vectors and compares every output on every cycle, and a few literal cycle
// numbers pin the model to hand-computed timing.
module tb_reqack_initiator;

  localparam int MAX       = 5;
  localparam int D         = 1;
  localparam int CNT_W     = 8;
  localparam int RETRY_MAX = 2;
  localparam int NCYC      = 1700;

  localparam int GOOD   = 0;
  localparam int NODONE = 1;
  localparam int SAME   = 2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             ack = 1'b0;
  logic             done = 1'b0;
  logic             req, intrpt, busy, timeout_err, proto_err;
  logic [CNT_W-1:0] txn_count;

  bit s_start [NCYC];
  bit s_ack   [NCYC];
  bit s_done  [NCYC];
  bit s_rst   [NCYC];
  bit e_req   [NCYC];
  bit e_intr  [NCYC];
  bit e_busy  [NCYC];
  bit e_terr  [NCYC];
  bit e_perr  [NCYC];
  bit e_inc   [NCYC];
  int e_cnt   [NCYC];

  int checks = 0;
  int failures = 0;

  reqack_initiator #(
    .MAX(MAX), .INTR_DLY(D), .CNT_W(CNT_W), .RETRY_MAX(RETRY_MAX)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .ack_i(ack), .done_i(done),
    .req_o(req), .intrpt_o(intrpt), .busy_o(busy), .timeout_err_o(timeout_err),
    .proto_err_o(proto_err), .txn_count_o(txn_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // One transaction: start at s; k = ack offset after req (0 = never acks).
  task automatic txn(input int s, input int k, input int mode, input bit hold, output int intr);
    int r, a, terr;
    s_start[s] = 1'b1;
    r = s + 1;
    e_req[r] = 1'b1;
    if (k == 0) begin
`ifdef REQACK_INIT_RETRY_EN
      for (int i = 0; i < RETRY_MAX; i++) begin
        r = r + MAX + 1;
        e_req[r] = 1'b1;
      end
`endif
      terr = r + MAX + 1;
      e_terr[terr] = 1'b1;
      intr = terr + 1 + D;
    end else begin
      a = s + 1 + k;
      s_ack[a] = 1'b1;
      if (mode == GOOD) begin
        s_done[a + 1] = 1'b1;
        e_inc[a + 2] = 1'b1;
        intr = a + 2 + D;
      end else if (mode == NODONE) begin
        e_perr[a + 2] = 1'b1;
        intr = a + 3 + D;
      end else begin
        s_done[a] = 1'b1;
        e_perr[a + 1] = 1'b1;
        intr = a + 2 + D;
      end
    end
    e_intr[intr] = 1'b1;
    for (int c = s + 1; c < intr; c++) e_busy[c] = 1'b1;
    if (hold) begin
      for (int c = s; c < intr; c++) s_start[c] = 1'b1;
    end
  endtask

  initial begin
    int t, intr, last_cyc, cnt, abort_t;
    int first_req, first_intr, first_terr, n_req, n_intr, n_terr;
    logic [31:0] cnt_before_abort;

    first_req = -1; first_intr = -1; first_terr = -1;
    n_req = 0; n_intr = 0; n_terr = 0;
    cnt_before_abort = '0;

    for (int c = 0; c < 3; c++) s_rst[c] = 1'b1;
    t = 4;
    txn(t, 2, GOOD, 1'b0, intr);   t = intr + 1;  // req@5 ack@7 done@8 intrpt@10
    txn(t, 5, GOOD, 1'b0, intr);   t = intr + 1;  // ack at the last legal cycle
    txn(t, 0, GOOD, 1'b0, intr);   t = intr + 1;  // never acks -> timeout
    txn(t, 2, NODONE, 1'b0, intr); t = intr + 1;  // missing done
    txn(t, 3, SAME, 1'b0, intr);   t = intr + 1;  // ack and done together
    s_ack[t + 1]  = 1'b1; e_perr[t + 2] = 1'b1;   // stray ack while idle
    s_done[t + 4] = 1'b1; e_perr[t + 5] = 1'b1;   // stray done while idle
    t = t + 7;
    txn(t, 1, GOOD, 1'b0, intr);   t = intr + 1;
    abort_t = t;                                  // reset during WAIT_DONE
    s_start[t] = 1'b1;
    e_req[t + 1] = 1'b1;
    for (int c = t + 1; c <= t + 3; c++) e_busy[c] = 1'b1;
    s_ack[t + 3] = 1'b1;
    s_rst[t + 4] = 1'b1;
    s_rst[t + 5] = 1'b1;
    t = t + 7;
    for (int i = 0; i < 256; i++) begin           // start held high, back to back
      txn(t, 1, GOOD, 1'b1, intr);
      t = intr;
    end
    last_cyc = t + 6;

    cnt = 0;
    for (int c = 0; c < NCYC; c++) begin
      if (s_rst[c]) cnt = 0;
      else if (e_inc[c]) cnt = (cnt + 1) % (1 << CNT_W);
      e_cnt[c] = cnt;
    end

    for (int c = 0; c < last_cyc; c++) begin
      @(posedge clk);
      #1;
      reset_n = !s_rst[c];
      start   = s_start[c];
      ack     = s_ack[c];
      done    = s_done[c];
      @(negedge clk);
      chk("req", c, req, e_req[c]);
      chk("intrpt", c, intrpt, e_intr[c]);
      chk("busy", c, busy, e_busy[c]);
      chk("timeout_err", c, timeout_err, e_terr[c]);
      chk("proto_err", c, proto_err, e_perr[c]);
      chk("txn_count", c, txn_count, e_cnt[c]);
      if (req === 1'b1) begin
        n_req++;
        if (first_req < 0) first_req = c;
      end
      if (intrpt === 1'b1) begin
        n_intr++;
        if (first_intr < 0) first_intr = c;
      end
      if (timeout_err === 1'b1) begin
        n_terr++;
        if (first_terr < 0) first_terr = c;
      end
      if (c == abort_t + 3) cnt_before_abort = txn_count;
    end

    chk("pin_first_req", 0, first_req, 5);
    chk("pin_first_intrpt", 0, first_intr, 10);
    chk("pin_n_intrpt", 0, n_intr, 262);
    chk("pin_n_timeout_err", 0, n_terr, 1);
    chk("pin_cnt_before_abort", 0, cnt_before_abort, 3);
    chk("pin_final_count_wrapped", 0, txn_count, 0);
`ifdef REQACK_INIT_RETRY_EN
    chk("pin_first_timeout_err", 0, first_terr, 40);
    chk("pin_n_req", 0, n_req, 265);
`else
    chk("pin_first_timeout_err", 0, first_terr, 28);
    chk("pin_n_req", 0, n_req, 263);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
